// File: rtl/sp_sram_pkg.sv
// Shared types and default geometry for the single-port scratch RAM.
package sp_sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_DEPTH      = 16;

endpackage

// File: rtl/sp_sram_array.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one registered read port.
module sp_sram_array
    import sp_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Callers only assert we/re for in-range addresses, so no bounds logic here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/single_port_sram.sv
// Single-port RAM on a shared tri-state bus; clears itself word by word after reset.
module single_port_sram
    import sp_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    sram_state_t           state_reg;
    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic                  zero_reg;
    logic                  busy_reg;

    logic                  in_range;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_waddr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic                  arr_re;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  drive;

    assign in_range = ({1'b0, addr} < DEPTH_W);

    // The clear sweep owns the write port until READY; a reset edge writes nothing.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = addr;
        arr_wdata = data;
        arr_re    = 1'b0;
        if (!rst) begin
            if (state_reg == CLEAR) begin
                arr_we    = 1'b1;
                arr_waddr = ptr_reg;
                arr_wdata = '0;
            end else begin
                arr_we = cs && we && in_range;
                arr_re = cs && !we && in_range;
            end
        end
    end

    sp_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (addr),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
            zero_reg  <= 1'b1;
            busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (ptr_reg == LAST_PTR) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                READY: begin
                    // Out-of-range reads and reset both present zero instead of the array output.
                    if (cs && !we) begin
                        zero_reg <= !in_range;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    assign rdata_q = zero_reg ? '0 : arr_rdata;
    assign drive   = (state_reg == READY) && cs && !we && oe;
    assign data    = drive ? rdata_q : 'z;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_single_port_sram.sv
// Randomized self-checking bench for single_port_sram against an array reference model.
module tb_single_port_sram;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int D  = 16;
    localparam int D2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          cs = 1'b0, we = 1'b0, oe = 1'b0;
    logic [AW-1:0] addr = '0;
    wire  [DW-1:0] data_bus;
    logic          tb_en = 1'b0;
    logic [DW-1:0] tb_drive = '0;
    logic          busy;

    logic          cs2 = 1'b0, we2 = 1'b0, oe2 = 1'b0;
    logic [AW-1:0] addr2 = '0;
    wire  [DW-1:0] data_bus2;
    logic          tb_en2 = 1'b0;
    logic [DW-1:0] tb_drive2 = '0;
    logic          busy2;

    assign data_bus  = tb_en  ? tb_drive  : 'z;
    assign data_bus2 = tb_en2 ? tb_drive2 : 'z;

    single_port_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk (clk), .rst (rst), .cs (cs), .we (we), .oe (oe),
        .addr (addr), .data (data_bus), .busy (busy)
    );

    single_port_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D2)) dut_small (
        .clk (clk), .rst (rst), .cs (cs2), .we (we2), .oe (oe2),
        .addr (addr2), .data (data_bus2), .busy (busy2)
    );

    int checks = 0;
    int fails  = 0;
    logic [DW-1:0] model [D];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset edge carries a would-be write that must be discarded.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; cs = 1'b1; we = 1'b1; oe = 1'b1;
        addr = AW'($urandom); tb_en = 1'b1; tb_drive = DW'($urandom);
        @(posedge clk); #1;
        check("busy_on_reset", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0; we = 1'b0; tb_en = 1'b0;
        for (int i = 0; i < D; i++) model[i] = '0;
    endtask

    task automatic wait_clear(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            addr = AW'($urandom); cs = 1'b1; we = 1'(($urandom) & 1); oe = 1'b1;
        end while (busy === 1'b1 && n < 100);
        check(tag, 32'(n), 32'(exp_cycles));
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic oe_v);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; oe = oe_v; addr = a; tb_en = 1'b1; tb_drive = d;
        @(posedge clk); #1;
        check("write_bus_undriven", 32'(data_bus), 32'(d));
        if (int'(a) < D) model[a] = d;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic oe_v);
        logic [DW-1:0] exp;
        @(negedge clk);
        cs = 1'b1; we = 1'b0; oe = oe_v; addr = a; tb_en = 1'b0;
        @(posedge clk); #1;
        exp = model[a];
        if (oe_v) begin
            check(tag, 32'(data_bus), 32'(exp));
        end else begin
            tb_en = 1'b1; tb_drive = '0; #1;
            check("hiz_oe_low", 32'(data_bus), 32'd0);
            tb_en = 1'b0;
        end
    endtask

    task automatic do_idle();
        @(negedge clk);
        cs = 1'b0; we = 1'(($urandom) & 1); oe = 1'b1; addr = AW'($urandom);
        tb_en = 1'b1; tb_drive = '0;
        @(posedge clk); #1;
        check("hiz_cs_low", 32'(data_bus), 32'd0);
        tb_en = 1'b0;
    endtask

    initial begin
        apply_reset();
        wait_clear("clear_cycles", D);
        for (int i = 0; i < D; i++) do_read("read_after_clear", AW'(i), 1'b1);

        for (int i = 0; i < D; i++) do_write(AW'(i), DW'($urandom), 1'b0);
        for (int i = 0; i < D; i++) do_read("readback", AW'(i), 1'b1);

        do_read("prime_nonzero", 4'd5, 1'b1);
        do_read("hiz", 4'd6, 1'b0);
        do_idle();
        do_idle();
        do_read("persist_after_idle", 4'd6, 1'b1);

        do_write(4'd3, 16'hA5A5, 1'b0);
        do_read("raw_a5a5", 4'd3, 1'b1);
        do_write(4'd3, 16'h5A5A, 1'b1);
        do_read("write_with_oe", 4'd3, 1'b1);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(3, 0))
                0: do_write(AW'($urandom), DW'($urandom), 1'(($urandom) & 1));
                1: do_read("rand_read", AW'($urandom), 1'b1);
                2: do_read("rand_read_oe0", AW'($urandom), 1'b0);
                default: do_idle();
            endcase
        end

        // Reset mid-clear at pointer 7 restarts the full sweep.
        apply_reset();
        repeat (7) @(posedge clk);
        apply_reset();
        wait_clear("clear_restart", D);
        for (int i = 0; i < D; i++) do_write(AW'(i), DW'($urandom) | 16'h1, 1'b0);
        apply_reset();
        wait_clear("clear_after_data", D);
        for (int i = 0; i < D; i++) do_read("zero_after_reset", AW'(i), 1'b1);

        // Small instance: addresses 12..15 are out of range.
        check("small_busy_done", 32'(busy2), 32'd0);
        @(negedge clk);
        cs2 = 1'b1; we2 = 1'b1; oe2 = 1'b0; addr2 = 4'd13; tb_en2 = 1'b1; tb_drive2 = 16'hBEEF;
        @(negedge clk);
        addr2 = 4'd5; tb_drive2 = 16'h1234;
        @(negedge clk);
        we2 = 1'b0; oe2 = 1'b1; addr2 = 4'd5; tb_en2 = 1'b0;
        @(posedge clk); #1;
        check("small_read_5", 32'(data_bus2), 32'h1234);
        @(negedge clk);
        addr2 = 4'd13;
        @(posedge clk); #1;
        check("small_read_13", 32'(data_bus2), 32'h0);
        @(negedge clk);
        addr2 = 4'd1;
        @(posedge clk); #1;
        check("small_read_1", 32'(data_bus2), 32'h0);
        @(negedge clk);
        cs2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/single_port_sram.md
# single_port_sram

Synchronous single-port RAM with a shared bidirectional data bus. Default size is 16 words of 16 bits. It serves as a small scratch memory for local controllers. A chip select, a write enable and an output enable control access, and the block drives the bus only during a qualified read. After reset it clears itself word by word and signals `busy` until the clear is done.

## Interface
- `ADDR_WIDTH`, 4, address bus width.
- `DATA_WIDTH`, 16, word width.
- `DEPTH`, 16, number of words. Must satisfy DEPTH ≤ 2**ADDR_WIDTH.

- `clk`  in  1  the only clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cs`  in  1  chip select; no access happens when low.
- `we`  in  1  write enable.
- `oe`  in  1  output enable; requests the DUT to drive `data`.
- `addr`  in  ADDR_WIDTH  word address.
- `data`  inout  DATA_WIDTH  shared data bus; high-Z unless the DUT is driving a read.
- `busy`  out  1  high while the post-reset clear is in progress.

## Operation
- States are CLEAR and READY.
- **Reset:**
  - `rst` sampled high enters CLEAR and sets the clear pointer to 0.
  - The read register `rdata_q` goes to 0.
  - `busy` goes to 1.
- **CLEAR:**
  - Each cycle writes 0 to mem[ptr], then increments ptr.
  - After ptr = DEPTH-1 is written, moves to READY and `busy` goes to 0.
  - All `cs`/`we`/`oe` activity is ignored and `data` stays high-Z.
- **READY, write:** at a rising edge with cs=1 and we=1, mem[addr] ← data. `oe` has no effect on writes.
- **READY, read:** at a rising edge with cs=1 and we=0, rdata_q ← mem[addr]. When cs=0, rdata_q holds its value.
- **Bus drive:** `data` = rdata_q only while READY, cs=1, we=0 and oe=1. Otherwise `data` is high-Z.
- **Bus contention:** cs=1, we=1, oe=1 together is a write. The DUT does not drive, so it never contends with the external driver.
- **Out-of-range address (addr ≥ DEPTH):**
  - Writes are dropped.
  - Reads load 0 into rdata_q.
- Memory contents persist across any number of idle cycles (cs=0).

## Timing
- Clear takes exactly DEPTH cycles after the last cycle `rst` is high. `busy` falls on the edge that writes the final word.
- Write latency is 1 edge. A read of the same address in the next cycle returns the new value.
- Read latency is 1 cycle. `addr` is sampled at edge N, and `data` is valid after edge N while the drive conditions hold.
- The drive enable is combinational from cs/we/oe/state. The bus releases in the same cycle that oe or cs falls, or we rises.
- **Read-after-write at the same address:** the write in cycle N is followed by a read registered at N+1, which returns the written word. There is no write-through within a single edge.
- **Reset mid-clear or mid-access:**
  - The clear restarts at ptr 0.
  - Any in-flight write on that edge is discarded.
  - rdata_q goes to 0.

## Structure
- Shared package `sp_sram_pkg`:
  - state enum {CLEAR, READY};
  - default width and depth constants.
- Sub-module `sp_sram_array` holds the DEPTH×DATA_WIDTH storage. Its interface is one synchronous write port (we, waddr, wdata) and one synchronous read port (raddr → rdata). The top level muxes the clear pointer and zero data into the write port during CLEAR.
- The top level holds the state register, the clear pointer, the range check and the tri-state driver.

## Test plan
- Reset, then cs=1 we=0 oe=1 at every address: `busy` is high for 16 cycles, and every read returns 0x0000.
- After clear, write 16 random words to addresses 0..15 with cs=1 we=1 oe=0 and the bench driving `data`. Then read them back with cs=1 we=0 oe=1. Each read returns its word 1 cycle after the address; `data` is high-Z during the writes.
- Hold oe=0 or cs=0 during a read cycle: `data` is high-Z, and stored contents are unchanged on a later read.
- Write 0xA5A5 to addr 3, then read addr 3 in the next cycle: returns 0xA5A5. A write with we=1 and oe=1 is accepted, and the DUT does not drive the bus.
- Assert `rst` for 1 cycle mid-clear (ptr 7) and again after data has been written: the clear restarts, `busy` lasts 16 more cycles, and every location reads 0.
- With DEPTH=12 and ADDR_WIDTH=4: a write to addr 13 is dropped, and a read of addr 13 returns 0x0000.
